// File: rtl/branch_ctrl.sv
// branch_ctrl: branch-resolution controller.
// Owns a direct-mapped pattern history table of 2-bit saturating counters
// used for fetch-time direction prediction. It trains the table from EX-stage
// resolves, sequences the redirect/flush on a mispredict, and keeps branch and
// mispredict statistics.
module branch_ctrl #(
   parameter int unsigned PHT_BITS    = 6,
   parameter int unsigned FLUSH_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] fetchPC,
   output logic        predTaken,
   input  logic        resValid,
   input  logic [31:0] resPC,
   input  logic        resTaken,
   input  logic        resPredTaken,
   input  logic [31:0] resTarget,
   input  logic [31:0] resFallthrough,
   output logic        redirect,
   output logic [31:0] redirectPC,
   output logic        flush,
   output logic [31:0] branchCount,
   output logic [31:0] mispredictCount
);

   localparam int unsigned PHT_ENTRIES = 1 << PHT_BITS;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REDIRECT = 2'd1;
   localparam logic [1:0] FLUSH    = 2'd2;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

   logic [1:0]          pht [PHT_ENTRIES];
   logic [1:0]          state, state_nx;
   logic [3:0]          flushcnt, flushcnt_nx;
   logic [PHT_BITS-1:0] fetch_idx, res_idx;
   logic [1:0]          res_ctr, res_ctr_nx;
   logic                accept, mispredict;
   logic                unused_pc_bits;

   assign fetch_idx = fetchPC[PHT_BITS+1:2];
   assign res_idx   = resPC[PHT_BITS+1:2];

   // Only the index bits of the PCs select a counter; the rest are don't-care.
   assign unused_pc_bits = ^{fetchPC[31:PHT_BITS+2], fetchPC[1:0],
                             resPC[31:PHT_BITS+2], resPC[1:0]};

   // Asynchronous read, no bypass: a same-cycle update is seen one cycle later.
   assign predTaken = pht[fetch_idx][1];
   assign res_ctr   = pht[res_idx];

   // Resolves are taken only when the pipeline advances and no redirect is in flight.
   assign accept     = resValid && !stall && (state == IDLE);
   assign mispredict = accept && (resTaken != resPredTaken);

   // Saturating counter step for the resolving branch.
   always_comb begin
      res_ctr_nx = res_ctr;
      if (resTaken) begin
         if (res_ctr != 2'b11) res_ctr_nx = res_ctr + 2'd1;
      end else begin
         if (res_ctr != 2'b00) res_ctr_nx = res_ctr - 2'd1;
      end
   end

   // PHT storage: all counters weak-not-taken after reset, trained on accepted resolves.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
            pht[PHT_BITS'(i)] <= 2'b01;
         end
      end else if (accept) begin
         pht[res_idx] <= res_ctr_nx;
      end
   end

   // Redirect/flush sequencer next-state; stall freezes REDIRECT and FLUSH.
   always_comb begin
      state_nx    = state;
      flushcnt_nx = flushcnt;
      case (state)
         IDLE: begin
            if (mispredict) begin
               state_nx    = REDIRECT;
               flushcnt_nx = FLUSH_LOAD;
            end
         end
         REDIRECT: begin
            if (!stall) state_nx = (flushcnt != '0) ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (!stall) begin
               flushcnt_nx = flushcnt - 4'd1;
               if (flushcnt == 4'd1) state_nx = IDLE;
            end
         end
         default: begin
            state_nx    = IDLE;
            flushcnt_nx = '0;
         end
      endcase
   end

   // State register; redirect/flush are registered decodes of the next state
   // so they line up exactly with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         flushcnt <= '0;
         redirect <= 1'b0;
         flush    <= 1'b0;
      end else begin
         state    <= state_nx;
         flushcnt <= flushcnt_nx;
         redirect <= (state_nx == REDIRECT);
         flush    <= (state_nx != IDLE);
      end
   end

   // Redirect target captured on a mispredict and held until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         redirectPC <= '0;
      end else if (mispredict) begin
         redirectPC <= resTaken ? resTarget : resFallthrough;
      end
   end

   // Statistics counters, wrapping mod 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (accept)     branchCount     <= branchCount + 32'd1;
         if (mispredict) mispredictCount <= mispredictCount + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed stimulus with a cycle-stamped expectation queue
// drained by an independent monitor on the falling edge.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset, stall, predTaken;
   logic [31:0] fetchPC;
   logic        resValid, resTaken, resPredTaken;
   logic [31:0] resPC, resTarget, resFallthrough;
   logic        redirect, flush;
   logic [31:0] redirectPC, branchCount, mispredictCount;

   branch_ctrl #(.PHT_BITS(6), .FLUSH_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .fetchPC(fetchPC),
      .predTaken(predTaken), .resValid(resValid), .resPC(resPC),
      .resTaken(resTaken), .resPredTaken(resPredTaken), .resTarget(resTarget),
      .resFallthrough(resFallthrough), .redirect(redirect),
      .redirectPC(redirectPC), .flush(flush), .branchCount(branchCount),
      .mispredictCount(mispredictCount)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   localparam int F_REDIR = 0, F_FLUSH = 1, F_RPC = 2, F_PRED = 3, F_BCNT = 4, F_MCNT = 5;

   int          q_cyc[$];
   int          q_fld[$];
   logic [31:0] q_val[$];
   string       q_name[$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic exp_chk(input string name, input int fld, input logic [31:0] val);
      q_cyc.push_back(cyc);
      q_fld.push_back(fld);
      q_val.push_back(val);
      q_name.push_back(name);
   endtask

   function automatic logic [31:0] actual(input int fld);
      case (fld)
         F_REDIR: return {31'd0, redirect};
         F_FLUSH: return {31'd0, flush};
         F_RPC:   return redirectPC;
         F_PRED:  return {31'd0, predTaken};
         F_BCNT:  return branchCount;
         default: return mispredictCount;
      endcase
   endfunction

   // Monitor: compare every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         n_cmp++;
         if (q_cyc[0] < cyc) begin
            n_err++;
            $display("FAIL %s: check missed (cycle %0d, now %0d)", q_name[0], q_cyc[0], cyc);
         end else if (actual(q_fld[0]) !== q_val[0]) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", q_name[0], actual(q_fld[0]), q_val[0]);
         end
         void'(q_cyc.pop_front());
         void'(q_fld.pop_front());
         void'(q_val.pop_front());
         void'(q_name.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic no_res();
      resValid = 1'b0;
      resPC = '0; resTaken = 1'b0; resPredTaken = 1'b0;
      resTarget = '0; resFallthrough = '0;
   endtask

   task automatic drive_res(input logic [31:0] pc, input logic tk, input logic pt,
                            input logic [31:0] tgt, input logic [31:0] ft);
      resValid = 1'b1;
      resPC = pc; resTaken = tk; resPredTaken = pt;
      resTarget = tgt; resFallthrough = ft;
   endtask

   logic sat_exp [7];

   initial begin
      sat_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      reset = 1'b1; stall = 1'b0; fetchPC = '0;
      no_res();
      step();
      step();
      // Reset state
      exp_chk("rst_redirect", F_REDIR, 32'd0);
      exp_chk("rst_flush", F_FLUSH, 32'd0);
      exp_chk("rst_rpc", F_RPC, 32'd0);
      exp_chk("rst_bcnt", F_BCNT, 32'd0);
      exp_chk("rst_mcnt", F_MCNT, 32'd0);
      reset = 1'b0;
      step();

      // Every counter reads weak-not-taken
      for (int i = 0; i < 64; i++) begin
         fetchPC = 32'h0040_0000 | (i << 2);
         exp_chk("init_pred", F_PRED, 32'd0);
         step();
      end

      // One taken resolve; same-cycle fetch shows the pre-update value
      fetchPC = 32'h0040_0010;
      drive_res(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0050, 32'h0040_0014);
      exp_chk("collide_pred", F_PRED, 32'd0);
      step();
      no_res();
      exp_chk("first_pred", F_PRED, 32'd1);
      exp_chk("first_bcnt", F_BCNT, 32'd1);
      step();

      // Reset pulse, then saturation run on a fresh table
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_chk("pulse_bcnt", F_BCNT, 32'd0);
      exp_chk("pulse_pred", F_PRED, 32'd0);
      step();

      fetchPC = 32'h0040_0020;
      for (int k = 0; k < 7; k++) begin
         drive_res(32'h0040_0020, (k < 5), (k < 5), 32'h0040_0060, 32'h0040_0024);
         exp_chk("sat_pred", F_PRED, {31'd0, sat_exp[k]});
         if (k == 6) exp_chk("sat_bcnt", F_BCNT, 32'd6);
         step();
      end
      no_res();
      exp_chk("sat_after_pred", F_PRED, 32'd0);
      exp_chk("sat_after_bcnt", F_BCNT, 32'd7);
      step();

      // Unstalled mispredict (taken, predicted not-taken)
      drive_res(32'h0040_0040, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0044);
      exp_chk("mp_pre_redirect", F_REDIR, 32'd0);
      exp_chk("mp_pre_flush", F_FLUSH, 32'd0);
      step();
      no_res();
      fetchPC = 32'h0040_0040;
      exp_chk("mp_redirect", F_REDIR, 32'd1);
      exp_chk("mp_rpc", F_RPC, 32'h0040_0100);
      exp_chk("mp_flush", F_FLUSH, 32'd1);
      exp_chk("mp_mcnt", F_MCNT, 32'd1);
      exp_chk("mp_bcnt", F_BCNT, 32'd8);
      exp_chk("mp_pred", F_PRED, 32'd1);
      step();
      exp_chk("mp_fl_redirect", F_REDIR, 32'd0);
      exp_chk("mp_fl_flush", F_FLUSH, 32'd1);
      step();
      exp_chk("mp_end_redirect", F_REDIR, 32'd0);
      exp_chk("mp_end_flush", F_FLUSH, 32'd0);
      step();

      // Not-taken mispredict; wrong-path resolves during REDIRECT and FLUSH
      drive_res(32'h0040_0080, 1'b0, 1'b1, 32'h0040_0200, 32'h0040_0084);
      step();
      drive_res(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0300, 32'h0040_0014);
      exp_chk("wp_redirect", F_REDIR, 32'd1);
      exp_chk("wp_rpc", F_RPC, 32'h0040_0084);
      exp_chk("wp_mcnt", F_MCNT, 32'd2);
      exp_chk("wp_bcnt", F_BCNT, 32'd9);
      step();
      exp_chk("wp_fl_redirect", F_REDIR, 32'd0);
      exp_chk("wp_fl_flush", F_FLUSH, 32'd1);
      step();
      no_res();
      fetchPC = 32'h0040_0010;
      exp_chk("wp_idle_flush", F_FLUSH, 32'd0);
      exp_chk("wp_idle_redirect", F_REDIR, 32'd0);
      exp_chk("wp_idle_bcnt", F_BCNT, 32'd9);
      exp_chk("wp_idle_mcnt", F_MCNT, 32'd2);
      exp_chk("wp_idle_rpc", F_RPC, 32'h0040_0084);
      exp_chk("wp_idle_pred", F_PRED, 32'd0);
      step();
      exp_chk("wp_noextra_redirect", F_REDIR, 32'd0);
      exp_chk("wp_noextra_flush", F_FLUSH, 32'd0);
      step();

      // Mispredict with 3 stall cycles in REDIRECT
      drive_res(32'h0040_0100, 1'b1, 1'b0, 32'h0040_0400, 32'h0040_0104);
      step();
      no_res();
      stall = 1'b1;
      exp_chk("st_rpc", F_RPC, 32'h0040_0400);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) stall = 1'b0;
         exp_chk("st_redirect", F_REDIR, 32'd1);
         exp_chk("st_flush", F_FLUSH, 32'd1);
         step();
      end
      exp_chk("st_fl_redirect", F_REDIR, 32'd0);
      exp_chk("st_fl_flush", F_FLUSH, 32'd1);
      step();
      // First IDLE cycle: back-to-back mispredict accepted here
      exp_chk("st_idle_flush", F_FLUSH, 32'd0);
      exp_chk("st_idle_redirect", F_REDIR, 32'd0);
      exp_chk("st_idle_mcnt", F_MCNT, 32'd3);
      exp_chk("st_idle_bcnt", F_BCNT, 32'd10);
      drive_res(32'h0040_0010, 1'b0, 1'b1, 32'h0040_0500, 32'h0040_0014);
      step();
      no_res();
      exp_chk("b2b_redirect", F_REDIR, 32'd1);
      exp_chk("b2b_rpc", F_RPC, 32'h0040_0014);
      exp_chk("b2b_mcnt", F_MCNT, 32'd4);
      exp_chk("b2b_bcnt", F_BCNT, 32'd11);
      step();
      // Reset during FLUSH
      exp_chk("b2b_fl_flush", F_FLUSH, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      fetchPC = 32'h0040_0100;
      exp_chk("rf_flush", F_FLUSH, 32'd0);
      exp_chk("rf_redirect", F_REDIR, 32'd0);
      exp_chk("rf_mcnt", F_MCNT, 32'd0);
      exp_chk("rf_bcnt", F_BCNT, 32'd0);
      exp_chk("rf_rpc", F_RPC, 32'd0);
      exp_chk("rf_pred", F_PRED, 32'd0);
      step();

      // Stall blocks a resolve in IDLE
      stall = 1'b1;
      drive_res(32'h0040_0100, 1'b1, 1'b0, 32'h0040_0600, 32'h0040_0104);
      step();
      stall = 1'b0;
      no_res();
      exp_chk("sb_redirect", F_REDIR, 32'd0);
      exp_chk("sb_flush", F_FLUSH, 32'd0);
      exp_chk("sb_bcnt", F_BCNT, 32'd0);
      exp_chk("sb_mcnt", F_MCNT, 32'd0);
      exp_chk("sb_pred", F_PRED, 32'd0);
      step();

      for (int i = 0; i < 10 && q_cyc.size() > 0; i++) step();
      if (q_cyc.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain: %0d checks pending, required 0", q_cyc.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
